// File: rtl/rvfi_csr_gen_if.sv
// rvfi_csr_gen_if: bundles the execute-side CSR access stream, the retire/flush
// controls and the RVFI CSR record outputs of rvfi_csr_gen.
//   master : produces ex_*, rt_valid, flush; consumes ex_ready, rvfi_*, protocol_err
//   slave  : the tracker itself (mirror of master)
interface rvfi_csr_gen_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            ex_valid;
    logic            ex_merge;
    logic [11:0]     ex_addr;
    logic [XLEN-1:0] ex_rmask;
    logic [XLEN-1:0] ex_wmask;
    logic [XLEN-1:0] ex_rdata;
    logic [XLEN-1:0] ex_wdata;
    logic            ex_ready;
    logic            rt_valid;
    logic            flush;
    logic            rvfi_valid;
    logic [XLEN-1:0] rvfi_csr_addr;
    logic [XLEN-1:0] rvfi_csr_rmask;
    logic [XLEN-1:0] rvfi_csr_wmask;
    logic [XLEN-1:0] rvfi_csr_rdata;
    logic [XLEN-1:0] rvfi_csr_wdata;
    logic            protocol_err;

    modport master (
        output ex_valid, ex_merge, ex_addr, ex_rmask, ex_wmask, ex_rdata, ex_wdata,
        output rt_valid, flush,
        input  ex_ready, rvfi_valid, rvfi_csr_addr, rvfi_csr_rmask, rvfi_csr_wmask,
        input  rvfi_csr_rdata, rvfi_csr_wdata, protocol_err
    );

    modport slave (
        input  ex_valid, ex_merge, ex_addr, ex_rmask, ex_wmask, ex_rdata, ex_wdata,
        input  rt_valid, flush,
        output ex_ready, rvfi_valid, rvfi_csr_addr, rvfi_csr_rmask, rvfi_csr_wmask,
        output rvfi_csr_rdata, rvfi_csr_wdata, protocol_err
    );
endinterface

// File: rtl/rvfi_csr_gen.sv
// rvfi_csr_gen: collects CSR accesses seen at execute into an in-order buffer,
// merging accesses of one instruction into a single entry, and emits one RVFI
// CSR record the cycle after the owning instruction retires.
//   clk    : sole clock, posedge
//   reset  : synchronous, active-high
//   io_bus : slave side of rvfi_csr_gen_if (execute stream, retire/flush, RVFI record)
module rvfi_csr_gen #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    rvfi_csr_gen_if.slave  io_bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [AW:0]     r_count;
    logic [11:0]     r_addr  [DEPTH];
    logic [XLEN-1:0] r_rmask [DEPTH];
    logic [XLEN-1:0] r_wmask [DEPTH];
    logic [XLEN-1:0] r_rdata [DEPTH];
    logic [XLEN-1:0] r_wdata [DEPTH];

    logic            r_valid;
    logic [XLEN-1:0] r_out_addr;
    logic [XLEN-1:0] r_out_rmask;
    logic [XLEN-1:0] r_out_wmask;
    logic [XLEN-1:0] r_out_rdata;
    logic [XLEN-1:0] r_out_wdata;
    logic            r_err;

    logic [AW-1:0]   w_young;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_merge_req;
    logic            w_merge_lost;
    logic            w_merge;
    logic            w_err;
    logic [XLEN-1:0] w_new_rbits;

    assign w_young = r_tail - AW'(1);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL);
    assign w_pop   = io_bus.rt_valid & ~w_empty;

    // A merge into an empty buffer has no entry to join, so it starts a new one.
    assign w_push = io_bus.ex_valid & (~io_bus.ex_merge | w_empty) & ~w_full & ~io_bus.flush;

    assign w_merge_req = io_bus.ex_valid & io_bus.ex_merge & ~w_empty & ~io_bus.flush;
    // With one entry the youngest is also the head being retired: the merge arrives too late.
    assign w_merge_lost = w_merge_req & io_bus.rt_valid & (r_count == ONE);
    assign w_merge      = w_merge_req & ~w_merge_lost;

    assign w_err = (w_merge & (io_bus.ex_addr != r_addr[w_young]))
                 | w_merge_lost
                 | (io_bus.ex_valid & ~io_bus.ex_merge & w_full)
                 | (io_bus.rt_valid & w_empty);

    // Only read bits not already captured take the new value; earlier reads win.
    assign w_new_rbits = io_bus.ex_rmask & ~r_rmask[w_young];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (io_bus.flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + AW'(w_pop);
                r_tail  <= r_tail + AW'(w_push);
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            r_err <= r_err | w_err;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail]  <= io_bus.ex_addr;
            r_rmask[r_tail] <= io_bus.ex_rmask;
            r_wmask[r_tail] <= io_bus.ex_wmask;
            r_rdata[r_tail] <= io_bus.ex_rdata;
            r_wdata[r_tail] <= io_bus.ex_wdata;
        end
        if (w_merge) begin
            r_rmask[w_young] <= r_rmask[w_young] | io_bus.ex_rmask;
            r_rdata[w_young] <= (r_rdata[w_young] & ~w_new_rbits)
                              | (io_bus.ex_rdata & w_new_rbits);
            r_wmask[w_young] <= r_wmask[w_young] | io_bus.ex_wmask;
            r_wdata[w_young] <= (r_wdata[w_young] & ~io_bus.ex_wmask)
                              | (io_bus.ex_wdata & io_bus.ex_wmask);
        end
    end

    // Record is the pre-merge head; flush does not suppress a same-cycle retire.
    always_ff @(posedge clk) begin
        if (reset || !w_pop) begin
            r_valid     <= 1'b0;
            r_out_addr  <= '0;
            r_out_rmask <= '0;
            r_out_wmask <= '0;
            r_out_rdata <= '0;
            r_out_wdata <= '0;
        end else begin
            r_valid     <= 1'b1;
            r_out_addr  <= XLEN'(r_addr[r_head]);
            r_out_rmask <= r_rmask[r_head];
            r_out_wmask <= r_wmask[r_head];
            r_out_rdata <= r_rdata[r_head];
            r_out_wdata <= r_wdata[r_head];
        end
    end

    assign io_bus.ex_ready       = ~w_full;
    assign io_bus.rvfi_valid     = r_valid;
    assign io_bus.rvfi_csr_addr  = r_out_addr;
    assign io_bus.rvfi_csr_rmask = r_out_rmask;
    assign io_bus.rvfi_csr_wmask = r_out_wmask;
    assign io_bus.rvfi_csr_rdata = r_out_rdata;
    assign io_bus.rvfi_csr_wdata = r_out_wdata;
    assign io_bus.protocol_err   = r_err;
endmodule

// File: tb/tb_rvfi_csr_gen.sv
// tb_rvfi_csr_gen: directed stimulus for rvfi_csr_gen; expected records are queued
// when stimulus is issued and a monitor compares every emitted record in order.
module tb_rvfi_csr_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rvfi_csr_gen_if #(.XLEN(32)) bus ();

    rvfi_csr_gen #(.XLEN(32), .DEPTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rmask;
        logic [31:0] rdata;
        logic [31:0] wmask;
        logic [31:0] wdata;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   occ, pushed, popped, iter;
    bit   do_push, do_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ex_valid = 1'b0;
        bus.ex_merge = 1'b0;
        bus.ex_addr  = '0;
        bus.ex_rmask = '0;
        bus.ex_rdata = '0;
        bus.ex_wmask = '0;
        bus.ex_wdata = '0;
        bus.rt_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic step();
        tick();
        idle();
    endtask

    task automatic drive_ex(input logic merge, input logic [11:0] a, input logic [31:0] rm,
                            input logic [31:0] rd, input logic [31:0] wm, input logic [31:0] wd);
        bus.ex_valid = 1'b1;
        bus.ex_merge = merge;
        bus.ex_addr  = a;
        bus.ex_rmask = rm;
        bus.ex_rdata = rd;
        bus.ex_wmask = wm;
        bus.ex_wdata = wd;
    endtask

    task automatic exp_rec(input logic [31:0] a, input logic [31:0] rm, input logic [31:0] rd,
                           input logic [31:0] wm, input logic [31:0] wd);
        exp_q.push_back('{a, rm, rd, wm, wd});
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every cycle either a queued record appears or all outputs are zero.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (bus.rvfi_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_record", bus.rvfi_csr_addr, 32'hFFFF_FFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rec_addr",  bus.rvfi_csr_addr,  mon_e.addr);
                        chk("rec_rmask", bus.rvfi_csr_rmask, mon_e.rmask);
                        chk("rec_rdata", bus.rvfi_csr_rdata, mon_e.rdata);
                        chk("rec_wmask", bus.rvfi_csr_wmask, mon_e.wmask);
                        chk("rec_wdata", bus.rvfi_csr_wdata, mon_e.wdata);
                    end
                end else begin
                    chk("idle_outputs_zero", bus.rvfi_csr_addr | bus.rvfi_csr_rmask
                        | bus.rvfi_csr_rdata | bus.rvfi_csr_wmask | bus.rvfi_csr_wdata, 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        mon_en = 1'b1;
        chk("reset_ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("reset_err", 32'(bus.protocol_err), 32'd0);

        // Basic push, retire two cycles later.
        drive_ex(1'b0, 12'h300, 32'hFFFF_FFFF, 32'h1800, 32'h8, 32'h1808);
        step();
        step();
        exp_rec(32'h300, 32'hFFFF_FFFF, 32'h1800, 32'h8, 32'h1808);
        bus.rt_valid = 1'b1;
        step();
        step();
        step();
        chk("basic_err", 32'(bus.protocol_err), 32'd0);

        // Merge: overlapping read bits keep the first value; write bits take the newest.
        drive_ex(1'b0, 12'h341, 32'h0000_FFFF, 32'h1234, 32'h0F, 32'h05);
        step();
        drive_ex(1'b1, 12'h341, 32'hFFFF_0000, 32'hABCD_5678, 32'hF0, 32'hA0);
        step();
        exp_rec(32'h341, 32'hFFFF_FFFF, 32'hABCD_1234, 32'hFF, 32'hA5);
        bus.rt_valid = 1'b1;
        step();
        step();
        chk("merge_err", 32'(bus.protocol_err), 32'd0);

        // Merge into youngest while the head retires in the same cycle.
        drive_ex(1'b0, 12'h305, 32'hF, 32'h1, 32'h0, 32'h0);
        step();
        drive_ex(1'b0, 12'h306, 32'hF, 32'h1, 32'h0, 32'h0);
        step();
        drive_ex(1'b1, 12'h306, 32'hF0, 32'h20, 32'h0, 32'h0);
        bus.rt_valid = 1'b1;
        exp_rec(32'h305, 32'hF, 32'h1, 32'h0, 32'h0);
        step();
        exp_rec(32'h306, 32'hFF, 32'h21, 32'h0, 32'h0);
        bus.rt_valid = 1'b1;
        step();
        step();
        chk("merge_pop_err", 32'(bus.protocol_err), 32'd0);

        // Fill to capacity, overflow, drain plus one extra retire.
        for (int i = 0; i < 4; i++) begin
            drive_ex(1'b0, 12'h100 + 12'(i), 32'h1, 32'(i), 32'h0, 32'h0);
            exp_rec(32'h100 + 32'(i), 32'h1, 32'(i), 32'h0, 32'h0);
            step();
        end
        chk("full_ex_ready", 32'(bus.ex_ready), 32'd0);
        chk("full_err_before", 32'(bus.protocol_err), 32'd0);
        drive_ex(1'b0, 12'h104, 32'h1, 32'h4, 32'h0, 32'h0);
        step();
        chk("overflow_err", 32'(bus.protocol_err), 32'd1);
        bus.rt_valid = 1'b1;
        repeat (5) tick();
        idle();
        tick();
        tick();
        do_reset();
        chk("post_reset_err", 32'(bus.protocol_err), 32'd0);

        // Flush with same-cycle retire and a discarded same-cycle push.
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b0, 12'h200 + 12'(i), 32'h3, 32'h7, 32'h0, 32'h0);
            step();
        end
        drive_ex(1'b0, 12'h2FF, 32'h3, 32'h7, 32'h0, 32'h0);
        bus.flush    = 1'b1;
        bus.rt_valid = 1'b1;
        exp_rec(32'h200, 32'h3, 32'h7, 32'h0, 32'h0);
        step();
        chk("flush_ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("flush_err", 32'(bus.protocol_err), 32'd0);
        bus.rt_valid = 1'b1;
        step();
        chk("flush_empty_retire_err", 32'(bus.protocol_err), 32'd1);
        step();
        do_reset();

        // Mixed push/pop traffic wrapping the pointers three times.
        occ = 0;
        pushed = 0;
        popped = 0;
        iter = 0;
        while (popped < 12 && iter < 1000) begin
            do_push = (pushed < 12) && (occ < 4) && ($urandom_range(0, 3) != 0);
            do_pop  = (occ > 0) && ($urandom_range(0, 2) != 0);
            if (do_push) begin
                drive_ex(1'b0, 12'h400 + 12'(pushed), 32'hFFFF_FFFF, 32'h1000 + 32'(pushed),
                         32'(pushed), ~32'(pushed));
                exp_rec(32'h400 + 32'(pushed), 32'hFFFF_FFFF, 32'h1000 + 32'(pushed),
                        32'(pushed), ~32'(pushed));
            end
            bus.rt_valid = do_pop;
            step();
            occ = occ + int'(do_push) - int'(do_pop);
            pushed = pushed + int'(do_push);
            popped = popped + int'(do_pop);
            iter++;
        end
        step();
        chk("stream_err", 32'(bus.protocol_err), 32'd0);
        chk("stream_ex_ready", 32'(bus.ex_ready), 32'd1);

        // Merge with a mismatching address: applied, address kept, error flagged.
        drive_ex(1'b0, 12'h310, 32'h1, 32'h1, 32'h0, 32'h0);
        step();
        drive_ex(1'b1, 12'h311, 32'h2, 32'h2, 32'h0, 32'h0);
        step();
        chk("addr_mismatch_err", 32'(bus.protocol_err), 32'd1);
        exp_rec(32'h310, 32'h3, 32'h3, 32'h0, 32'h0);
        bus.rt_valid = 1'b1;
        step();
        step();
        do_reset();

        // Merge racing the retire of the only entry: pre-merge contents retire.
        drive_ex(1'b0, 12'h307, 32'h1, 32'h1, 32'h0, 32'h0);
        step();
        drive_ex(1'b1, 12'h307, 32'h2, 32'h2, 32'h0, 32'h0);
        bus.rt_valid = 1'b1;
        exp_rec(32'h307, 32'h1, 32'h1, 32'h0, 32'h0);
        step();
        chk("late_merge_err", 32'(bus.protocol_err), 32'd1);
        step();
        do_reset();

        // Push into a full buffer with a same-cycle retire is refused.
        for (int i = 0; i < 4; i++) begin
            drive_ex(1'b0, 12'h500 + 12'(i), 32'h1, 32'h0, 32'h0, 32'h0);
            exp_rec(32'h500 + 32'(i), 32'h1, 32'h0, 32'h0, 32'h0);
            step();
        end
        drive_ex(1'b0, 12'h504, 32'h1, 32'h0, 32'h0, 32'h0);
        bus.rt_valid = 1'b1;
        step();
        chk("full_pop_push_err", 32'(bus.protocol_err), 32'd1);
        chk("full_pop_ex_ready", 32'(bus.ex_ready), 32'd1);
        bus.rt_valid = 1'b1;
        repeat (3) tick();
        idle();
        tick();
        tick();
        do_reset();

        // Reset with pending entries and a retire in the same cycle.
        bus.rt_valid = 1'b1;
        step();
        chk("empty_retire_err", 32'(bus.protocol_err), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive_ex(1'b0, 12'h600 + 12'(i), 32'h1, 32'h0, 32'h0, 32'h0);
            step();
        end
        reset = 1'b1;
        bus.rt_valid = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("reset_flight_ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("reset_flight_err", 32'(bus.protocol_err), 32'd0);
        tick();
        tick();

        chk("records_outstanding", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rvfi_csr_gen.md
RVFI_CSR_GEN -- requirements
Module: rvfi_csr_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32: data/mask width.
REQ-002 SHALL have parameter DEPTH, default 4: pending-entry capacity, power of 2, >=2.
REQ-003 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ex_valid  in  1  CSR access observed at execute.
REQ-006 SHALL have port ex_merge  in  1  access belongs to the same instruction as the youngest entry.
REQ-007 SHALL have port ex_addr  in  12  CSR address.
REQ-008 SHALL have ports ex_rmask, ex_wmask, ex_rdata, ex_wdata  in  XLEN  access masks and data.
REQ-009 SHALL have port ex_ready  out  1  room for a new entry.
REQ-010 SHALL have port rt_valid  in  1  oldest CSR-accessing instruction retires.
REQ-011 SHALL have port flush  in  1  discard all pending entries.
REQ-012 SHALL have port rvfi_valid  out  1  RVFI CSR record valid.
REQ-013 SHALL have port rvfi_csr_addr  out  XLEN  CSR address, zero-extended.
REQ-014 SHALL have ports rvfi_csr_rmask, rvfi_csr_wmask, rvfi_csr_rdata, rvfi_csr_wdata  out  XLEN  RVFI CSR record.
REQ-015 SHALL have port protocol_err  out  1  sticky protocol violation flag.

Function
REQ-016 SHALL hold entries {addr, rmask, wmask, rdata, wdata} in an in-order circular buffer of DEPTH entries with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-017 SHALL drive ex_ready = (count != DEPTH), combinationally from registered count.
REQ-018 SHALL push at tail when ex_valid & ~ex_merge & ex_ready & ~flush.
REQ-019 SHALL treat ex_valid & ex_merge with count==0 as a push.
REQ-020 SHALL merge into youngest entry when ex_valid & ex_merge & count>0 & ~flush: rmask |= ex_rmask; rdata bits in (ex_rmask & ~old rmask) take ex_rdata, others kept; wmask |= ex_wmask; wdata bits in ex_wmask take ex_wdata, others kept.
REQ-021 SHALL accept a merge regardless of ex_ready.
REQ-022 SHALL set protocol_err when a merge addr differs from youngest entry addr; merge still applied, addr unchanged.
REQ-023 SHALL drop ex_valid & ~ex_merge when count==DEPTH (no state change) and set protocol_err.
REQ-024 SHALL pop head when rt_valid & count>0; next cycle rvfi_valid=1 and rvfi_csr_* = popped entry (latency exactly 1 cycle).
REQ-025 SHALL drive rvfi_valid=0 and all rvfi_csr_* = 0 in every cycle not following a pop.
REQ-026 SHALL set protocol_err on rt_valid with count==0; rvfi_valid stays 0.
REQ-027 SHALL on simultaneous push and pop perform both; count unchanged; push into a full buffer with same-cycle pop SHALL NOT be accepted (ex_ready uses pre-pop count).
REQ-028 SHALL on rt_valid & ex_merge with count==1 retire pre-merge contents, discard the merge, set protocol_err.
REQ-029 SHALL on rt_valid & ex_merge with count>1 apply merge to youngest and pop head in the same cycle.
REQ-030 SHALL on flush clear count and pointers to 0 and discard same-cycle push/merge; same-cycle rt_valid with count>0 SHALL still emit the head record next cycle.
REQ-031 SHALL keep protocol_err set until reset.

Reset
REQ-032 SHALL when reset=1 at posedge set count, head, tail, rvfi_valid, all rvfi_csr_*, protocol_err to 0; ex_ready=1 the following cycle.
REQ-033 SHALL give reset priority over all inputs; in-flight entries and a pending output record are discarded.

Verification
REQ-034 Push addr 0x300 rmask=0xFFFFFFFF rdata=0x1800 wmask=0x8 wdata=0x1808, rt_valid two cycles later -> next cycle rvfi_valid=1, addr=0x300, rmask=0xFFFFFFFF, rdata=0x1800, wmask=0x8, wdata=0x1808; following cycle all outputs 0.
REQ-035 Push 0x341 rmask=0x0000FFFF rdata=0x1234, merge rmask=0xFFFF0000 rdata=0xABCD5678, retire -> rmask=0xFFFFFFFF, rdata=0xABCD1234; protocol_err=0.
REQ-036 Push 4 entries (DEPTH=4) -> ex_ready=0; 5th push dropped, protocol_err=1; 4 retires emit addrs in push order; 5th retire gives rvfi_valid=0.
REQ-037 Push 3 entries, assert flush with rt_valid same cycle -> one record (first entry) next cycle, count=0, ex_ready=1, later rt_valid sets protocol_err.
REQ-038 Fill and drain 3*DEPTH entries with random simultaneous push/pop -> pointers wrap, output order equals push order, no protocol_err.
REQ-039 Assert reset with 2 pending entries and rt_valid high -> next cycle rvfi_valid=0, ex_ready=1, protocol_err=0.
